// File: rtl/fpu_sequencer.sv
// Multicycle sequencer for the iterative FPU datapath: load, N iterate cycles, write-back.
// Optional feature macro: FPU_DIV_EN makes FPUOp=11 a legal FDIV taking DIV_CYCLES iterations.
module fpu_sequencer #(
  parameter int unsigned ADD_CYCLES = 3,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 12
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [1:0] fpu_op_i,
  input  logic       flush_i,
  output logic       op_load_o,
  output logic       fpu_step_o,
  output logic       result_wen_o,
  output logic [1:0] fpu_op_q_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       illegal_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StExec = 2'b10,
    StWb   = 2'b11
  } state_e;

  if (ADD_CYCLES == 0 || ADD_CYCLES > 15 || MUL_CYCLES == 0 || MUL_CYCLES > 15 ||
      DIV_CYCLES == 0 || DIV_CYCLES > 15) begin : gen_param_check
    $error("fpu_sequencer: cycle-count parameters must lie in 1..15");
  end

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  logic       op_legal;
  logic [3:0] op_cycles_m1;

  // Counter preload is N-1 so that the EXEC phase lasts exactly N cycles.
  always_comb begin
    op_legal     = 1'b1;
    op_cycles_m1 = 4'(ADD_CYCLES - 1);
    case (fpu_op_i)
      2'b00, 2'b01: op_cycles_m1 = 4'(ADD_CYCLES - 1);
      2'b10:        op_cycles_m1 = 4'(MUL_CYCLES - 1);
      default: begin
`ifdef FPU_DIV_EN
        op_cycles_m1 = 4'(DIV_CYCLES - 1);
`else
        op_legal = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    illegal_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (op_legal) begin
            state_d = StLoad;
            op_d    = fpu_op_i;
            cnt_d   = op_cycles_m1;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StLoad: state_d = StExec;
      StExec: begin
        if (cnt_q == 4'd0) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWb: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Flush overrides everything, including a request arriving in the same IDLE cycle.
    if (flush_i) begin
      state_d   = StIdle;
      cnt_d     = 4'd0;
      op_d      = op_q;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      op_q      <= 2'b00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    op_load_o    = (state_q == StLoad);
    fpu_step_o   = (state_q == StExec);
    result_wen_o = (state_q == StWb);
    done_o       = (state_q == StWb);
    busy_o       = (state_q != StIdle);
    fpu_op_q_o   = op_q;
    illegal_o    = illegal_q;
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: directed steps plus random traffic against a
// timeline model (cycles elapsed since accept determine every strobe).
module tb_fpu_sequencer;

  localparam int unsigned AddN = 3;
  localparam int unsigned MulN = 4;
  localparam int unsigned DivN = 12;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [1:0] fpu_op_i;
  logic       flush_i;
  logic       op_load_o;
  logic       fpu_step_o;
  logic       result_wen_o;
  logic [1:0] fpu_op_q_o;
  logic       busy_o;
  logic       done_o;
  logic       illegal_o;

  int errors = 0;
  int checks = 0;

  // Reference model: k = cycles since accept (0 = idle), n = iteration count of the op.
  int         m_k;
  int         m_n;
  logic [1:0] m_op;
  logic       m_ill;
  int         loads_seen;

  fpu_sequencer #(
    .ADD_CYCLES(AddN),
    .MUL_CYCLES(MulN),
    .DIV_CYCLES(DivN)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .fpu_op_i    (fpu_op_i),
    .flush_i     (flush_i),
    .op_load_o   (op_load_o),
    .fpu_step_o  (fpu_step_o),
    .result_wen_o(result_wen_o),
    .fpu_op_q_o  (fpu_op_q_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit op_is_legal(input logic [1:0] op);
`ifdef FPU_DIV_EN
    return 1'b1;
`else
    return op != 2'b11;
`endif
  endfunction

  function automatic int op_len(input logic [1:0] op);
    if (op == 2'b10) return int'(MulN);
    if (op == 2'b11) return int'(DivN);
    return int'(AddN);
  endfunction

  task automatic model_reset();
    m_k   = 0;
    m_n   = 0;
    m_op  = 2'b00;
    m_ill = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic [1:0] op, input logic f);
    bit was_idle;
    was_idle = (m_k == 0);
    m_ill    = 1'b0;
    if (f) begin
      m_k = 0;
    end else begin
      if (!was_idle) m_k = (m_k == m_n + 2) ? 0 : m_k + 1;
      if (was_idle && s) begin
        if (op_is_legal(op)) begin
          m_k  = 1;
          m_n  = op_len(op);
          m_op = op;
        end else begin
          m_ill = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("op_load", {1'b0, op_load_o}, {1'b0, m_k == 1});
    chk("fpu_step", {1'b0, fpu_step_o}, {1'b0, m_k >= 2 && m_k <= m_n + 1});
    chk("result_wen", {1'b0, result_wen_o}, {1'b0, m_k != 0 && m_k == m_n + 2});
    chk("done", {1'b0, done_o}, {1'b0, m_k != 0 && m_k == m_n + 2});
    chk("busy", {1'b0, busy_o}, {1'b0, m_k != 0});
    chk("fpu_op_q", fpu_op_q_o, m_op);
    chk("illegal", {1'b0, illegal_o}, {1'b0, m_ill});
  endtask

  // One clock: drive inputs away from the edge, advance the model at the edge, check at negedge.
  task automatic cyc(input logic s, input logic [1:0] op, input logic f);
    start_i  = s;
    fpu_op_i = op;
    flush_i  = f;
    @(posedge clk_i);
    if (!rst_ni) model_reset();
    else model_edge(s, op, f);
    @(negedge clk_i);
    if (op_load_o) loads_seen++;
    check_all();
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b1;
    fpu_op_i   = 2'b10;
    flush_i    = 1'b0;
    loads_seen = 0;
    model_reset();

    // Reset held three cycles with Start asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_all();
    end
    rst_ni = 1'b1;

    // FMUL accepted on the first sampled Start after release.
    cyc(1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'b00, 1'b0);

    // FADD then FSUB with Start held high; requests during Busy are ignored.
    loads_seen = 0;
    for (int i = 0; i < 12; i++) cyc(1'b1, (i < 6) ? 2'b00 : 2'b01, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 2'b00, 1'b0);
    chk("b2b_loads", 2'(loads_seen), 2'd2);

    // Flush in the second EXEC cycle of an FMUL, then a normal FADD.
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 2'b00, 1'b0);

    // Flush and Start together in IDLE: request dropped.
    cyc(1'b1, 2'b01, 1'b1);
    cyc(1'b0, 2'b00, 1'b0);

    // Opcode 11: rejected by default, FDIV when the divide path is built in.
    cyc(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 2'b00, 1'b0);

    // Asynchronous reset between clock edges during EXEC.
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
    #2 rst_ni = 1'b0;
    #1 model_reset();
    check_all();
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'b00, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
